// File: rtl/Shared_Pkg.sv
// Shared definitions for the synchronous FIFO and its read-side controller.
//   FIFO_WIDTH : FIFO word width
//   RD_CNT_W   : width of the optional delivered-word counter
//   rd_state_e : occupancy states of the read-side skid buffer
package Shared_Pkg;

  localparam int FIFO_WIDTH = 16;
  localparam int RD_CNT_W   = 16;

  typedef enum logic [1:0] {
    RD_EMPTY = 2'd0,
    RD_ONE   = 2'd1,
    RD_TWO   = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry output skid buffer for fifo_read_ctrl.
// Entry r_head is always the oldest word; r_tail only holds a second word.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   i_push        : write i_push_data at the tail this cycle
//   i_push_data   : word to write
//   i_pop         : head word is consumed this cycle
//   o_occ         : number of buffered words (0..2)
//   o_head        : oldest buffered word
//
// state    | meaning
// ---------+------------------------------------------
// RD_EMPTY | no word buffered
// RD_ONE   | one word, in r_head
// RD_TWO   | two words, oldest in r_head, next in r_tail
module fifo_rd_skid_buf
  import Shared_Pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [1:0]            o_occ,
  output logic [DATA_WIDTH-1:0] o_head
);

  rd_state_e             r_state;
  rd_state_e             w_state_nxt;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic                  w_head_load_push;
  logic                  w_head_load_tail;
  logic                  w_tail_load;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= RD_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // A push in RD_TWO cannot occur: the issue logic in the top never lets
  // more than two words be committed.
  always_comb begin
    w_state_nxt      = r_state;
    w_head_load_push = 1'b0;
    w_head_load_tail = 1'b0;
    w_tail_load      = 1'b0;
    case (r_state)
      RD_EMPTY: begin
        if (i_push) begin
          w_state_nxt      = RD_ONE;
          w_head_load_push = 1'b1;
        end
      end
      RD_ONE: begin
        if (i_push && i_pop) begin
          w_head_load_push = 1'b1;
        end else if (i_push) begin
          w_state_nxt = RD_TWO;
          w_tail_load = 1'b1;
        end else if (i_pop) begin
          w_state_nxt = RD_EMPTY;
        end
      end
      RD_TWO: begin
        if (i_pop) begin
          w_state_nxt      = RD_ONE;
          w_head_load_tail = 1'b1;
        end
      end
      default: w_state_nxt = RD_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_head_load_push)      r_head <= i_push_data;
      else if (w_head_load_tail) r_head <= r_tail;
      if (w_tail_load)           r_tail <= i_push_data;
    end
  end

  always_comb begin
    case (r_state)
      RD_ONE:  o_occ = 2'd1;
      RD_TWO:  o_occ = 2'd2;
      default: o_occ = 2'd0;
    endcase
  end

  assign o_head = r_head;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller for the synchronous FIFO. Issues FIFO reads so that
// the 2-entry skid buffer is never over-committed, captures the read data one
// cycle later and presents it on a valid/ready stream in FIFO order.
// Optional feature macro: FIFO_RD_STATS_EN (adds the rd_count port).
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   fifo_empty       : FIFO empty flag
//   fifo_underflow   : FIFO underflow flag, registered after an illegal read
//   fifo_data_out    : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en       : FIFO read request
//   m_valid/m_ready  : downstream stream handshake
//   m_data           : stream data (oldest buffered word)
//   err_underflow    : sticky underflow seen on one of our reads
//   rd_count         : saturating count of delivered words (FIFO_RD_STATS_EN)
module fifo_read_ctrl
  import Shared_Pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_WIDTH,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  err_underflow
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [RD_CNT_W-1:0]   rd_count
`endif
);

  if (BUF_DEPTH != 2) begin : g_bad_depth
    $error("fifo_read_ctrl: only BUF_DEPTH == 2 is supported");
  end

  logic       r_pending;
  logic       r_err;
  logic [1:0] w_occ;
  logic       w_pop;
  logic       w_capture;
  logic [2:0] w_commit;

  assign w_pop     = m_valid && m_ready;
  assign w_capture = r_pending && !fifo_underflow;

  // Words that will sit in the buffer after this cycle if nothing new is
  // issued; a pending read counts even if it later turns out to underflow.
  assign w_commit   = {1'b0, w_occ} + {2'b00, r_pending} - {2'b00, w_pop};
  assign fifo_rd_en = rst_n && !fifo_empty && (w_commit < 3'd2);
  assign m_valid    = (w_occ != 2'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= fifo_rd_en;
      if (r_pending && fifo_underflow) r_err <= 1'b1;
    end
  end

  assign err_underflow = r_err;

  fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_capture),
    .i_push_data (fifo_data_out),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_head      (m_data)
  );

`ifdef FIFO_RD_STATS_EN
  logic [RD_CNT_W-1:0] r_rd_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_count <= '0;
    end else if (w_pop && (r_rd_count != {RD_CNT_W{1'b1}})) begin
      r_rd_count <= r_rd_count + {{(RD_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign rd_count = r_rd_count;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Testbench for fifo_read_ctrl. Models the FIFO read port (1-cycle latency,
// registered underflow) and checks delivered words against a scoreboard.
module tb_fifo_read_ctrl;
  import Shared_Pkg::*;

  localparam int DW = FIFO_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_underflow = 1'b0;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          err_underflow;
`ifdef FIFO_RD_STATS_EN
  logic [RD_CNT_W-1:0] rd_count;
`endif

  int tests_run = 0;
  int n_fail    = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] sb_q[$];
  int  rd_pulses = 0;
  int  xfers     = 0;
  int  cyc       = 0;
  int  first_xfer_cyc = -1;
  int  last_xfer_cyc  = -1;
  bit  force_uf  = 1'b0;

  fifo_read_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_data_out  (fifo_data_out),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .err_underflow  (err_underflow)
`ifdef FIFO_RD_STATS_EN
    ,
    .rd_count       (rd_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic push_word(input logic [DW-1:0] w, input bit expect_out);
    fifo_q.push_back(w);
    if (expect_out) sb_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle: sample at negedge, then model the FIFO response #1
  // after the rising edge.
  task automatic tick();
    logic          rd;
    logic [DW-1:0] exp_w;
    @(negedge clk);
    rd = fifo_rd_en;
    if (rd) rd_pulses++;
    if (m_valid && m_ready) begin
      xfers++;
      if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
      last_xfer_cyc = cyc;
      tests_run++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got m_data=%h, required no transfer", m_data);
      end else begin
        exp_w = sb_q.pop_front();
        if (m_data !== exp_w) begin
          n_fail++;
          $display("FAIL sb_data: got m_data=%h, required %h", m_data, exp_w);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rd && fifo_q.size() > 0) begin
      fifo_data_out  = fifo_q.pop_front();
      fifo_underflow = force_uf;
      force_uf       = 1'b0;
    end else begin
      fifo_underflow = rd;
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic clear_counts();
    rd_pulses = 0;
    xfers = 0;
    first_xfer_cyc = -1;
    last_xfer_cyc = -1;
  endtask

  task automatic wait_xfers(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (xfers < n && k < budget) begin
      tick();
      k++;
    end
    tests_run++;
    if (xfers != n) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d transfers, required %0d", name, xfers, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_ready = 1'b0;
    tick();
    tick();
    tests_run++;
    if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || err_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd_en=%b valid=%b data=%h err=%b, required 0 0 0000 0",
               fifo_rd_en, m_valid, m_data, err_underflow);
    end
`ifdef FIFO_RD_STATS_EN
    tests_run++;
    if (rd_count !== '0) begin
      n_fail++;
      $display("FAIL reset_rd_count: got %h, required 0000", rd_count);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_reset_midstream();
    clear_counts();
    m_ready = 1'b0;
    push_word(16'hA001, 1'b0);
    push_word(16'hA002, 1'b0);
    push_word(16'hA003, 1'b0);
    tick();
    tests_run++;
    if (rd_pulses != 1) begin
      n_fail++;
      $display("FAIL midrst_issue: got %0d rd_en pulses, required 1", rd_pulses);
    end
    rst_n = 1'b0;
    tick();
    tests_run++;
    if (m_valid !== 1'b0 || err_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got valid=%b err=%b, required 0 0", m_valid, err_underflow);
    end
`ifdef FIFO_RD_STATS_EN
    tests_run++;
    if (rd_count !== '0) begin
      n_fail++;
      $display("FAIL midrst_rd_count: got %h, required 0000", rd_count);
    end
`endif
    fifo_q.delete();
    fifo_empty = 1'b1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_no_deliver: cycle %0d got valid=%b data=%h, required valid 0", i, m_valid, m_data);
      end
    end
    m_ready = 1'b0;
  endtask

  task automatic test_streaming();
    clear_counts();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(DW'(i), 1'b1);
    wait_xfers(8, 40, "stream");
    tests_run++;
    if (last_xfer_cyc - first_xfer_cyc != 7) begin
      n_fail++;
      $display("FAIL stream_consecutive: got span %0d cycles, required 7", last_xfer_cyc - first_xfer_cyc);
    end
    for (int i = 0; i < 3; i++) tick();
    tests_run++;
    if (rd_pulses != 8 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_rd_en: got %0d pulses, %0d left, required 8 pulses, 0 left", rd_pulses, sb_q.size());
    end
`ifdef FIFO_RD_STATS_EN
    tests_run++;
    if (rd_count !== 16'd8) begin
      n_fail++;
      $display("FAIL stream_rd_count: got %0d, required 8", rd_count);
    end
`endif
    m_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    clear_counts();
    m_ready = 1'b0;
    push_word(16'hB0B1, 1'b1);
    push_word(16'hB0B2, 1'b1);
    push_word(16'hB0B3, 1'b1);
    push_word(16'hB0B4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (m_valid) begin
        tests_run++;
        if (m_data !== 16'hB0B1) begin
          n_fail++;
          $display("FAIL bp_hold: cycle %0d got m_data=%h, required b0b1", i, m_data);
        end
      end
    end
    tests_run++;
    if (rd_pulses != 2 || m_valid !== 1'b1 || m_data !== 16'hB0B1) begin
      n_fail++;
      $display("FAIL bp_state: got pulses=%0d valid=%b data=%h, required 2 1 b0b1", rd_pulses, m_valid, m_data);
    end
    m_ready = 1'b1;
    wait_xfers(4, 30, "bp_drain");
    tests_run++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_loss: got %0d words undelivered, required 0", sb_q.size());
    end
    m_ready = 1'b0;
  endtask

  task automatic test_empty();
    clear_counts();
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL empty_idle: cycle %0d got rd_en=%b valid=%b, required 0 0", i, fifo_rd_en, m_valid);
      end
    end
    m_ready = 1'b0;
  endtask

  task automatic test_underflow();
    int k;
    clear_counts();
    m_ready = 1'b0;
    push_word(16'hC0C1, 1'b1);
    k = 0;
    while (!m_valid && k < 10) begin
      tick();
      k++;
    end
    tests_run++;
    if (m_valid !== 1'b1 || err_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL uf_setup: got valid=%b err=%b, required 1 0", m_valid, err_underflow);
    end
    push_word(16'hDEAD, 1'b0);
    force_uf = 1'b1;
    tick();
    tick();
    tests_run++;
    if (err_underflow !== 1'b1 || m_valid !== 1'b1 || m_data !== 16'hC0C1) begin
      n_fail++;
      $display("FAIL uf_drop: got err=%b valid=%b data=%h, required 1 1 c0c1", err_underflow, m_valid, m_data);
    end
    m_ready = 1'b1;
    push_word(16'hC0C2, 1'b1);
    push_word(16'hC0C3, 1'b1);
    wait_xfers(3, 30, "uf_drain");
    for (int i = 0; i < 3; i++) tick();
    tests_run++;
    if (err_underflow !== 1'b1 || m_valid !== 1'b0 || sb_q.size() != 0 || xfers != 3) begin
      n_fail++;
      $display("FAIL uf_after: got err=%b valid=%b left=%0d xfers=%0d, required 1 0 0 3",
               err_underflow, m_valid, sb_q.size(), xfers);
    end
    m_ready = 1'b0;
  endtask

`ifdef FIFO_RD_STATS_EN
  task automatic test_stats_saturation();
    clear_counts();
    m_ready = 1'b0;
    force dut.r_rd_count = 16'hFFFE;
    tick();
    release dut.r_rd_count;
    tick();
    tests_run++;
    if (rd_count !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL stats_preload: got %h, required fffe", rd_count);
    end
    m_ready = 1'b1;
    push_word(16'hE001, 1'b1);
    push_word(16'hE002, 1'b1);
    push_word(16'hE003, 1'b1);
    wait_xfers(3, 30, "stats");
    tick();
    tests_run++;
    if (rd_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL stats_saturate: got %h, required ffff", rd_count);
    end
    m_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_reset_midstream();
    test_streaming();
    test_backpressure();
    test_empty();
    test_underflow();
`ifdef FIFO_RD_STATS_EN
    test_stats_saturation();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, n_fail);
    $finish;
  end

endmodule
